// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between icache and dcache line transactions
// Fixed priority on ties, with a bounded streak so the losing side is eventually forced through.
module mem_port_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int LINE_W     = 256,
   parameter bit D_PRIORITY = 1'b1,
   parameter int MAX_CONSEC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_e;

   localparam logic [3:0] MAX_C    = 4'(MAX_CONSEC);
   localparam state_e     PRIO_ST  = D_PRIORITY ? SERVE_D : SERVE_I;
   localparam state_e     OTHER_ST = D_PRIORITY ? SERVE_I : SERVE_D;

   state_e     state_q, state_d;
   logic [3:0] consec_q, consec_d;
   logic       i_req, d_req;

   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // Strobes and responses follow the live request and mem_resp so a withdrawal drops them at once.
   always_comb begin
      state_d   = state_q;
      consec_d  = consec_q;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req && d_req) begin
               if (consec_q < MAX_C) begin
                  state_d  = PRIO_ST;
                  consec_d = consec_q + 4'd1;
               end else begin
                  state_d  = OTHER_ST;
                  consec_d = '0;
               end
            end else if (i_req) begin
               state_d  = SERVE_I;
               consec_d = '0;
            end else if (d_req) begin
               state_d  = SERVE_D;
               consec_d = '0;
            end
         end
         SERVE_I: begin
            mem_read = i_read;
            mem_addr = i_addr;
            if (mem_resp) begin
               i_resp  = 1'b1;
               state_d = RELEASE;
            end else if (!i_req) begin
               state_d = IDLE;
            end
         end
         SERVE_D: begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_write = d_write;
            mem_read  = d_read & ~d_write;
            if (mem_resp) begin
               d_resp  = 1'b1;
               state_d = RELEASE;
            end else if (!d_req) begin
               state_d = IDLE;
            end
         end
         RELEASE: begin
            if (!mem_resp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         consec_q <= '0;
      end else begin
         state_q  <= state_d;
         consec_q <= consec_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 256;
   localparam bit DP     = 1'b1;
   localparam int MC     = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_read, d_read, d_write, mem_resp;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [LINE_W-1:0] d_wdata, mem_rdata;
   logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
   logic              i_resp, d_resp, mem_read, mem_write;
   logic [ADDR_W-1:0] mem_addr;

   int tests = 0;
   int fails = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .D_PRIORITY(DP), .MAX_CONSEC(MC)) dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        rst, ir;
      logic [15:0] ia;
      logic        dr, dw;
      logic [15:0] da;
      logic [7:0]  wb;
      logic        mr;
      logic [7:0]  rb;
      logic        erd, ewr;
      logic [15:0] ea;
      logic [7:0]  ewb;
      logic        eir, edr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic ir, logic [15:0] ia, logic dr, logic dw,
                               logic [15:0] da, logic [7:0] wb, logic mr, logic [7:0] rb,
                               logic erd, logic ewr, logic [15:0] ea, logic [7:0] ewb,
                               logic eir, logic edr);
      vec_t v;
      v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wb = wb;
      v.mr = mr; v.rb = rb; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ewb = ewb;
      v.eir = eir; v.edr = edr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
   endtask

   // behavioural reference: phase 0 idle, 1 icache owns port, 2 dcache owns port, 3 cooling down
   int m_phase, m_streak;

   function automatic int pick_winner(logic want_i, logic want_d, inout int streak);
      if (want_i && want_d) begin
         if (streak < MC) begin streak = streak + 1; return DP ? 2 : 1; end
         streak = 0;
         return DP ? 1 : 2;
      end
      if (want_i || want_d) streak = 0;
      return want_i ? 1 : (want_d ? 2 : 0);
   endfunction

   logic [LINE_W-1:0] rep;
   logic [7:0]        exp_g[10];
   logic [7:0]        got_g;

   initial begin
      reset = 1;
      idle_inputs();

      // single icache read, held mem_resp, simultaneous requests, write precedence, withdrawal
      tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1240,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0,1,16'h1240,0,0,16'h0000,8'h00,0,8'h00, 1,0,16'h1240,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1240,0,0,16'h0000,8'h00,1,8'hA5, 1,0,16'h1240,8'h00,1,0));
      tbl.push_back(mk(0,0,16'h1240,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,0,8'h00, 1,0,16'h1250,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,1,8'h5A, 1,0,16'h1250,8'h00,1,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,1,8'h5A, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,1,8'h5A, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,0,8'h00, 1,0,16'h1250,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h1250,0,0,16'h0000,8'h00,1,8'h11, 1,0,16'h1250,8'h00,1,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(1,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,1,16'h3000,8'h3C,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,1,16'h3000,8'h3C,0,8'h00, 0,1,16'h3000,8'h3C,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,1,16'h3000,8'h3C,1,8'h77, 0,1,16'h3000,8'h3C,0,1));
      tbl.push_back(mk(0,1,16'h2000,0,0,16'h3000,8'h3C,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,0,16'h3000,8'h3C,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,0,16'h3000,8'h3C,0,8'h00, 1,0,16'h2000,8'h00,0,0));
      tbl.push_back(mk(0,1,16'h2000,0,0,16'h3000,8'h3C,1,8'hC3, 1,0,16'h2000,8'h00,1,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,1,16'h3100,8'h66,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,1,16'h3100,8'h66,0,8'h00, 0,1,16'h3100,8'h66,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,1,16'h3100,8'h66,1,8'h21, 0,1,16'h3100,8'h66,0,1));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,0,16'h4400,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,0,16'h4400,8'h00,0,8'h00, 1,0,16'h4400,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h4400,8'h00,0,8'h00, 0,0,16'h4400,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,0,16'h4400,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,0,16'h4400,8'h00,0,8'h00, 1,0,16'h4400,8'h00,0,0));
      tbl.push_back(mk(0,0,16'h0000,1,0,16'h4400,8'h00,1,8'h9E, 1,0,16'h4400,8'h00,0,1));
      tbl.push_back(mk(0,0,16'h0000,0,0,16'h0000,8'h00,0,8'h00, 0,0,16'h0000,8'h00,0,0));

      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge clk); #1;
         reset    = tbl[k].rst;
         i_read   = tbl[k].ir;
         i_addr   = tbl[k].ia;
         d_read   = tbl[k].dr;
         d_write  = tbl[k].dw;
         d_addr   = tbl[k].da;
         d_wdata  = {32{tbl[k].wb}};
         mem_resp = tbl[k].mr;
         mem_rdata = {32{tbl[k].rb}};
         #3;
         chk($sformatf("row%0d mem_read", k), LINE_W'(mem_read), LINE_W'(tbl[k].erd));
         chk($sformatf("row%0d mem_write", k), LINE_W'(mem_write), LINE_W'(tbl[k].ewr));
         chk($sformatf("row%0d mem_addr", k), LINE_W'(mem_addr), LINE_W'(tbl[k].ea));
         chk($sformatf("row%0d mem_wdata", k), mem_wdata, {32{tbl[k].ewb}});
         chk($sformatf("row%0d i_resp", k), LINE_W'(i_resp), LINE_W'(tbl[k].eir));
         chk($sformatf("row%0d d_resp", k), LINE_W'(d_resp), LINE_W'(tbl[k].edr));
         chk($sformatf("row%0d i_rdata", k), i_rdata, {32{tbl[k].rb}});
         chk($sformatf("row%0d d_rdata", k), d_rdata, {32{tbl[k].rb}});
      end

      // starvation bound: both sides keep requesting
      do_reset();
      for (int k = 0; k < 10; k++)
         exp_g[k] = ((k % (MC + 1)) == MC) ? (DP ? "I" : "D") : (DP ? "D" : "I");
      i_read = 1; i_addr = 16'h6000; d_write = 1; d_addr = 16'h5000;
      d_wdata = {32{8'h5C}};
      begin
         int ng = 0;
         for (int c = 0; c < 200 && ng < 10; c++) begin
            @(posedge clk); #1;
            mem_resp = 0;
            #2;
            if (mem_read || mem_write) begin
               got_g = mem_write ? "D" : "I";
               chk($sformatf("grant%0d", ng), LINE_W'(got_g), LINE_W'(exp_g[ng]));
               mem_resp = 1;
               #1;
               chk($sformatf("grant%0d resp", ng), LINE_W'({i_resp, d_resp}),
                   LINE_W'((got_g == "D") ? 2'b01 : 2'b10));
               ng++;
            end
         end
         chk("starvation grant count", LINE_W'(ng), LINE_W'(10));
      end

      // asynchronous reset during a dcache writeback
      do_reset();
      d_write = 1; d_addr = 16'h7000; d_wdata = {32{8'h99}};
      @(posedge clk); #3;
      chk("arst pre mem_write", LINE_W'(mem_write), LINE_W'(1));
      #1 reset = 1;
      #1;
      chk("arst mem_write", LINE_W'(mem_write), LINE_W'(0));
      chk("arst mem_addr", LINE_W'(mem_addr), LINE_W'(0));
      chk("arst mem_wdata", mem_wdata, '0);
      @(posedge clk); #1;
      reset = 0; d_write = 0;
      #3;
      chk("post arst outputs", LINE_W'({mem_read, mem_write, i_resp, d_resp}), LINE_W'(0));
      chk("post arst addr/wdata", mem_wdata | LINE_W'(mem_addr), '0);
      @(posedge clk); #1;
      i_read = 1; i_addr = 16'h0ABC;
      #3;
      chk("post arst idle strobe", LINE_W'(mem_read), LINE_W'(0));
      @(posedge clk); #4;
      chk("post arst grant", LINE_W'({mem_read, mem_addr}), LINE_W'({1'b1, 16'h0ABC}));

      // randomized traffic against the reference model
      do_reset();
      m_phase = 0; m_streak = 0;
      begin
         logic last_ir = 0, last_dr = 0;
         logic e_rd, e_wr, e_ir, e_dr;
         logic [ADDR_W-1:0] e_addr;
         logic [LINE_W-1:0] e_wd;
         int nxt;
         for (int c = 0; c < 3000; c++) begin
            if (i_read) begin
               if (last_ir || $urandom_range(0, 19) == 0) i_read = 0;
            end else if ($urandom_range(0, 2) == 0) begin
               i_read = 1; i_addr = ADDR_W'($urandom);
            end
            if (d_read || d_write) begin
               if (last_dr || $urandom_range(0, 19) == 0) begin d_read = 0; d_write = 0; end
            end else if ($urandom_range(0, 2) == 0) begin
               int op = $urandom_range(0, 7);
               d_write = (op < 3) || (op == 7);
               d_read  = (op >= 3);
               d_addr  = ADDR_W'($urandom);
               for (int w = 0; w < LINE_W / 32; w++) d_wdata[w*32 +: 32] = $urandom;
            end
            mem_resp = ($urandom_range(0, 2) == 0);
            for (int w = 0; w < LINE_W / 32; w++) mem_rdata[w*32 +: 32] = $urandom;
            #3;
            e_rd   = (m_phase == 1 && i_read) || (m_phase == 2 && d_read && !d_write);
            e_wr   = (m_phase == 2) && d_write;
            e_addr = (m_phase == 1) ? i_addr : ((m_phase == 2) ? d_addr : '0);
            e_wd   = (m_phase == 2) ? d_wdata : '0;
            e_ir   = (m_phase == 1) && mem_resp;
            e_dr   = (m_phase == 2) && mem_resp;
            chk($sformatf("rand%0d strobes/resps", c), LINE_W'({mem_read, mem_write, i_resp, d_resp}),
                LINE_W'({e_rd, e_wr, e_ir, e_dr}));
            chk($sformatf("rand%0d mem_addr", c), LINE_W'(mem_addr), LINE_W'(e_addr));
            chk($sformatf("rand%0d mem_wdata", c), mem_wdata, e_wd);
            chk($sformatf("rand%0d rdata", c), i_rdata ^ d_rdata ^ mem_rdata, mem_rdata);
            case (m_phase)
               0: nxt = pick_winner(i_read, d_read || d_write, m_streak);
               1: nxt = mem_resp ? 3 : (i_read ? 1 : 0);
               2: nxt = mem_resp ? 3 : ((d_read || d_write) ? 2 : 0);
               default: nxt = mem_resp ? 3 : 0;
            endcase
            m_phase = nxt;
            last_ir = e_ir;
            last_dr = e_dr;
            @(posedge clk); #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
